// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: valid/ready frame request handshake into the UART transmit controller
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    modport master(output tx_data, output tx_valid, input tx_ready);
    modport slave(input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer driving an external LSB-first PISO shift register
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input logic clk,
    input logic reset,
    uart_tx_ctrl_if.slave req,
    output logic [DATA_WIDTH-1:0] piso_data,
    output logic piso_load,
    output logic piso_shift,
    input logic piso_q,
    output logic tx,
    output logic busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic acc, done;
    assign acc = req.tx_valid && req.tx_ready;
    assign done = cnt == CNT_LAST;
    always_comb begin
        state_n = state == IDLE ? (acc ? START : IDLE) :
                  !done ? state :
                  state == START ? DATA :
                  state == DATA ? (idx == IDX_LAST ? STOP : DATA) : IDLE;
        cnt_n = (state == IDLE || done) ? '0 : cnt + 1'b1;
        idx_n = state != DATA ? '0 : done ? idx + 1'b1 : idx;
    end
    // Shift strobe is derived from the next state so it lands on the last cycle of a bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            tx <= 1'b1;
            req.tx_ready <= 1'b1;
            busy <= 1'b0;
            piso_load <= 1'b0;
            piso_shift <= 1'b0;
            piso_data <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            tx <= state == START ? 1'b0 : state == DATA ? piso_q : 1'b1;
            req.tx_ready <= state_n == IDLE;
            busy <= state_n != IDLE;
            piso_load <= acc;
            piso_shift <= state_n == DATA && cnt_n == CNT_LAST && idx_n != IDX_LAST;
            if (acc) piso_data <= req.tx_data;
        end
    end
endmodule
